pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
Central hazard and sequencing controller for the 5-stage RV32 pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB registers).
- Generates per-stage stall, bubble and flush controls.
- Generates operand forwarding selects for EX.
- Runs a small FSM that holds the pipe during multi-cycle data-memory accesses and drains fetch after a control redirect.
- Sits beside the datapath; consumes only register addresses and control bits from each pipeline register.

Parameters:
REG_ADDR_WIDTH, 5, register address width (RegAddrWidth)
REDIRECT_CYCLES, 1, extra cycles flush_if is held after a redirect (fetch latency), range 0..15
MEM_TIMEOUT, 256, MEM_WAIT cycles before an access is aborted, >=2
CNT_WIDTH, 32, width of stall performance counter

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous, active-high reset
id_valid  input  1  IF/ID holds a valid instruction
id_rs1_addr, id_rs2_addr  input  REG_ADDR_WIDTH  decode-stage source registers
id_rs1_used, id_rs2_used  input  1  source actually read by the instruction
ex_valid  input  1  ID/EX ctrl.valid
ex_rs1_addr, ex_rs2_addr  input  REG_ADDR_WIDTH  EX-stage source registers
ex_rd_addr  input  REG_ADDR_WIDTH  EX destination
ex_wb_en, ex_is_load  input  1  EX writes back / is a load
ex_redirect  input  1  EX resolved taken branch/jump (mispredict)
mem_valid, mem_wb_en, mem_is_load  input  1  EX/MEM ctrl bits
mem_rd_addr  input  REG_ADDR_WIDTH  MEM destination
mem_req  input  1  MEM stage issuing a data-memory access this cycle
mem_ack  input  1  data memory completes the access
wb_valid, wb_wb_en  input  1  MEM/WB ctrl bits
wb_rd_addr  input  REG_ADDR_WIDTH  WB destination
stall_if, stall_id, stall_ex, stall_mem  output  1  hold the PC / IF/ID / ID/EX / EX/MEM register
bubble_ex  output  1  load ID/EX with valid=0
bubble_wb  output  1  load MEM/WB with valid=0
flush_if  output  1  invalidate IF/ID
flush_id  output  1  invalidate ID/EX
fwd_rs1_sel, fwd_rs2_sel  output  2  00 regfile, 01 EX/MEM result, 10 MEM/WB result
mem_fault  output  1  one-cycle pulse: access aborted by timeout
stall_cycles  output  CNT_WIDTH  count of cycles with stall_if=1

Behaviour:
- FSM states: RUN, MEM_WAIT, REDIRECT. Registered state, redirect counter (4b), timeout counter, stall_cycles; all other outputs are combinational from inputs and state.
- Reset (rst=1):
  - Next state RUN; counters 0; mem_fault 0; stall_cycles 0.
  - While rst=1: flush_if=flush_id=1; all other outputs 0.
- Register x0 never matches any hazard or forward (addr==0 ignored).
- Forwarding (EX operands):
  - Select 01 if mem_valid & mem_wb_en & !mem_is_load & mem_rd_addr==ex_rsN_addr.
  - Else select 10 if wb_valid & wb_wb_en & wb_rd_addr==ex_rsN_addr.
  - Else 00. MEM has priority over WB.
- Load-use hazard:
  - Condition: ex_valid & ex_is_load & ex_wb_en & id_valid & (id_rs1_used & id_rs1_addr==ex_rd_addr | id_rs2_used & id_rs2_addr==ex_rd_addr).
  - Response: stall_if=stall_id=bubble_ex=1 for exactly that cycle. No state change.
- Memory stall (RUN):
  - mem_valid & mem_req & !mem_ack → stall_if/id/ex/mem=1, bubble_wb=1 this cycle, next state MEM_WAIT, timeout counter cleared.
  - mem_req & mem_ack in the same cycle → no stall.
- MEM_WAIT:
  - All four stalls and bubble_wb asserted, except in a cycle with mem_ack=1, where none are asserted and next state is RUN.
  - Timeout counter increments each cycle. When it reaches MEM_TIMEOUT-1 without ack: mem_fault pulses, bubble_wb=1, stalls released, next state RUN.
  - mem_ack arriving on the timeout cycle wins: no fault.
- Redirect:
  - ex_valid & ex_redirect with no memory stall that cycle → flush_if=flush_id=1.
  - If REDIRECT_CYCLES>0: next state REDIRECT, counter=REDIRECT_CYCLES.
  - REDIRECT state: flush_if=1; counter decrements; at 1 → RUN.
  - A new redirect in REDIRECT reloads the counter.
  - REDIRECT_CYCLES=0: stay in RUN.
- Simultaneous events:
  - Memory stall beats redirect: EX is held, so ex_redirect is re-presented and taken in the cycle the stall releases.
  - Redirect beats load-use: no stall, no bubble_ex; the flush kills ID.
  - Load-use while in MEM_WAIT: the memory stall covers it; bubble_ex=0.
  - mem_req arriving while in REDIRECT: treated as in RUN (enter MEM_WAIT); flush_if stays asserted until its count expires.
- stall_cycles increments every cycle stall_if=1 and wraps at 2^CNT_WIDTH.
- rst asserted mid-MEM_WAIT or mid-REDIRECT → RUN next edge, no mem_fault.

Test Plan:
- Forwarding: ex_rs1_addr=5 with mem_rd_addr=5 and wb_rd_addr=5 (both wb_en) → fwd_rs1_sel=01. mem_is_load=1 → 10. Address 0 → 00.
- Load-use: ex load rd=7, id rs2=7 used → stall_if/stall_id/bubble_ex=1 for one cycle; stall_cycles +1. id_rs2_used=0 → no stall.
- Memory wait: mem_req at cycle 0, mem_ack at cycle 3 → stalls=1 and bubble_wb=1 in cycles 0-2; all 0 in cycle 3; state RUN at cycle 4; stall_cycles=3.
- Timeout: MEM_TIMEOUT=4, mem_req with no ack → mem_fault pulses in the 4th MEM_WAIT cycle (timeout counter=3); stalls released that cycle; state RUN next.
- Redirect: REDIRECT_CYCLES=2, ex_redirect at cycle 0 → flush_id=1 at cycle 0 only; flush_if=1 in cycles 0-2; RUN at cycle 3. A second redirect at cycle 1 extends flush_if through cycle 3.
- Priority: redirect + load-use same cycle → flush only, bubble_ex=0. Redirect + unacked mem_req → stall, no flush until the ack cycle. Reset mid-MEM_WAIT → RUN, counters 0.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_if.sv
// pipeline_hazard_ctrl_if: pipeline control bits in, stall/flush/forward controls out.
interface pipeline_hazard_ctrl_if #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CNT_WIDTH      = 32
);
    logic                      id_valid;
    logic [REG_ADDR_WIDTH-1:0] id_rs1_addr;
    logic [REG_ADDR_WIDTH-1:0] id_rs2_addr;
    logic                      id_rs1_used;
    logic                      id_rs2_used;
    logic                      ex_valid;
    logic [REG_ADDR_WIDTH-1:0] ex_rs1_addr;
    logic [REG_ADDR_WIDTH-1:0] ex_rs2_addr;
    logic [REG_ADDR_WIDTH-1:0] ex_rd_addr;
    logic                      ex_wb_en;
    logic                      ex_is_load;
    logic                      ex_redirect;
    logic                      mem_valid;
    logic                      mem_wb_en;
    logic                      mem_is_load;
    logic [REG_ADDR_WIDTH-1:0] mem_rd_addr;
    logic                      mem_req;
    logic                      mem_ack;
    logic                      wb_valid;
    logic                      wb_wb_en;
    logic [REG_ADDR_WIDTH-1:0] wb_rd_addr;
    logic                      stall_if;
    logic                      stall_id;
    logic                      stall_ex;
    logic                      stall_mem;
    logic                      bubble_ex;
    logic                      bubble_wb;
    logic                      flush_if;
    logic                      flush_id;
    logic [1:0]                fwd_rs1_sel;
    logic [1:0]                fwd_rs2_sel;
    logic                      mem_fault;
    logic [CNT_WIDTH-1:0]      stall_cycles;

    modport master (
        output id_valid, id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used,
               ex_valid, ex_rs1_addr, ex_rs2_addr, ex_rd_addr, ex_wb_en, ex_is_load, ex_redirect,
               mem_valid, mem_wb_en, mem_is_load, mem_rd_addr, mem_req, mem_ack,
               wb_valid, wb_wb_en, wb_rd_addr,
        input  stall_if, stall_id, stall_ex, stall_mem, bubble_ex, bubble_wb,
               flush_if, flush_id, fwd_rs1_sel, fwd_rs2_sel, mem_fault, stall_cycles
    );

    modport slave (
        input  id_valid, id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used,
               ex_valid, ex_rs1_addr, ex_rs2_addr, ex_rd_addr, ex_wb_en, ex_is_load, ex_redirect,
               mem_valid, mem_wb_en, mem_is_load, mem_rd_addr, mem_req, mem_ack,
               wb_valid, wb_wb_en, wb_rd_addr,
        output stall_if, stall_id, stall_ex, stall_mem, bubble_ex, bubble_wb,
               flush_if, flush_id, fwd_rs1_sel, fwd_rs2_sel, mem_fault, stall_cycles
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: 5-stage pipe hazard detection, forwarding and memory/redirect sequencing.
module pipeline_hazard_ctrl #(
    parameter int REG_ADDR_WIDTH  = 5,
    parameter int REDIRECT_CYCLES = 1,
    parameter int MEM_TIMEOUT     = 256,
    parameter int CNT_WIDTH       = 32
) (
    input logic                  clk,
    input logic                  rst,
    pipeline_hazard_ctrl_if.slave bus
);
    localparam int TW = $clog2(MEM_TIMEOUT);

    typedef enum logic [1:0] {RUN, MEM_WAIT, REDIRECT} state_e;

    state_e               state_q, state_d;
    logic [3:0]           rcnt_q, rcnt_d;
    logic [TW-1:0]        tmo_q, tmo_d;
    logic [CNT_WIDTH-1:0] stall_cycles_q;

    logic mem_fwd_ok, wb_fwd_ok;
    logic in_wait, tmo_hit, mem_start, mem_stall, fault;
    logic redirect_take, load_use, lu_stall;

    assign mem_fwd_ok = bus.mem_valid && bus.mem_wb_en && !bus.mem_is_load && bus.mem_rd_addr != '0;
    assign wb_fwd_ok  = bus.wb_valid && bus.wb_wb_en && bus.wb_rd_addr != '0;

    // A load result only exists after MEM, so only WB may forward it
    assign bus.fwd_rs1_sel = rst ? 2'b00
                           : (mem_fwd_ok && bus.mem_rd_addr == bus.ex_rs1_addr) ? 2'b01
                           : (wb_fwd_ok && bus.wb_rd_addr == bus.ex_rs1_addr)   ? 2'b10 : 2'b00;
    assign bus.fwd_rs2_sel = rst ? 2'b00
                           : (mem_fwd_ok && bus.mem_rd_addr == bus.ex_rs2_addr) ? 2'b01
                           : (wb_fwd_ok && bus.wb_rd_addr == bus.ex_rs2_addr)   ? 2'b10 : 2'b00;

    assign in_wait   = state_q == MEM_WAIT;
    assign tmo_hit   = tmo_q == TW'(MEM_TIMEOUT - 1);
    assign mem_start = !in_wait && bus.mem_valid && bus.mem_req && !bus.mem_ack;
    assign mem_stall = mem_start || (in_wait && !bus.mem_ack && !tmo_hit);
    assign fault     = in_wait && !bus.mem_ack && tmo_hit;

    // EX is frozen under a memory stall, so the redirect is re-presented on release
    assign redirect_take = bus.ex_valid && bus.ex_redirect && !mem_stall;

    assign load_use = bus.ex_valid && bus.ex_is_load && bus.ex_wb_en && bus.ex_rd_addr != '0 &&
                      bus.id_valid &&
                      ((bus.id_rs1_used && bus.id_rs1_addr == bus.ex_rd_addr) ||
                       (bus.id_rs2_used && bus.id_rs2_addr == bus.ex_rd_addr));
    assign lu_stall = load_use && !mem_stall && !redirect_take;

    assign bus.stall_if     = !rst && (mem_stall || lu_stall);
    assign bus.stall_id     = !rst && (mem_stall || lu_stall);
    assign bus.stall_ex     = !rst && mem_stall;
    assign bus.stall_mem    = !rst && mem_stall;
    assign bus.bubble_ex    = !rst && lu_stall;
    assign bus.bubble_wb    = !rst && (mem_stall || fault);
    assign bus.mem_fault    = !rst && fault;
    assign bus.flush_id     = rst || redirect_take;
    assign bus.flush_if     = rst || redirect_take || rcnt_q != '0;
    assign bus.stall_cycles = stall_cycles_q;

    // Redirect drain counter keeps running even if a memory stall interrupts it
    always_comb begin
        rcnt_d  = redirect_take ? 4'(REDIRECT_CYCLES) : (rcnt_q != '0) ? rcnt_q - 4'd1 : 4'd0;
        tmo_d   = mem_start ? '0 : in_wait ? tmo_q + TW'(1) : tmo_q;
        state_d = mem_start                                    ? MEM_WAIT
                : (in_wait && !bus.mem_ack && !tmo_hit)        ? MEM_WAIT
                : (rcnt_d != '0)                               ? REDIRECT : RUN;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= RUN;
            rcnt_q         <= '0;
            tmo_q          <= '0;
            stall_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            rcnt_q         <= rcnt_d;
            tmo_q          <= tmo_d;
            stall_cycles_q <= stall_cycles_q + CNT_WIDTH'(bus.stall_if);
        end
    end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed checks of forwarding, hazards, memory wait, timeout and redirect.
module tb_pipeline_hazard_ctrl;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipeline_hazard_ctrl_if #(.REG_ADDR_WIDTH(5), .CNT_WIDTH(32)) bus();

    pipeline_hazard_ctrl #(
        .REG_ADDR_WIDTH(5), .REDIRECT_CYCLES(2), .MEM_TIMEOUT(4), .CNT_WIDTH(32)
    ) dut (.clk(clk), .rst(rst), .bus(bus));

    // {stall_if, stall_id, stall_ex, stall_mem, bubble_ex, bubble_wb, flush_if, flush_id, mem_fault}
    logic [8:0] ctl;
    assign ctl = {bus.stall_if, bus.stall_id, bus.stall_ex, bus.stall_mem, bus.bubble_ex,
                  bus.bubble_wb, bus.flush_if, bus.flush_id, bus.mem_fault};

    localparam logic [8:0] C_NONE = 9'b000000000;
    localparam logic [8:0] C_FL   = 9'b000000110;
    localparam logic [8:0] C_FIF  = 9'b000000100;
    localparam logic [8:0] C_MEM  = 9'b111101000;
    localparam logic [8:0] C_MEMF = 9'b111101100;
    localparam logic [8:0] C_LU   = 9'b110010000;
    localparam logic [8:0] C_FLT  = 9'b000001001;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic look(input string tag, input logic [8:0] exp);
        #1;
        chk(tag, 32'(ctl), 32'(exp));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.id_valid = 0; bus.id_rs1_addr = 0; bus.id_rs2_addr = 0;
        bus.id_rs1_used = 0; bus.id_rs2_used = 0;
        bus.ex_valid = 0; bus.ex_rs1_addr = 0; bus.ex_rs2_addr = 0; bus.ex_rd_addr = 0;
        bus.ex_wb_en = 0; bus.ex_is_load = 0; bus.ex_redirect = 0;
        bus.mem_valid = 0; bus.mem_wb_en = 0; bus.mem_is_load = 0; bus.mem_rd_addr = 0;
        bus.mem_req = 0; bus.mem_ack = 0;
        bus.wb_valid = 0; bus.wb_wb_en = 0; bus.wb_rd_addr = 0;
    endtask

    task automatic set_load_use(input logic [4:0] rd);
        bus.ex_valid = 1; bus.ex_is_load = 1; bus.ex_wb_en = 1; bus.ex_rd_addr = rd;
        bus.id_valid = 1; bus.id_rs2_addr = rd; bus.id_rs2_used = 1;
    endtask

    task automatic set_mem_req();
        bus.mem_valid = 1; bus.mem_req = 1; bus.mem_ack = 0;
    endtask

    task automatic set_redirect();
        bus.ex_valid = 1; bus.ex_redirect = 1;
    endtask

    initial begin
        rst = 1;
        idle();
        tick();
        tick();
        look("rst_ctl", C_FL);
        chk("rst_cnt", bus.stall_cycles, 0);
        set_load_use(5'd7);
        look("rst_lu", C_FL);
        idle();
        rst = 0;
        tick();
        look("run_idle", C_NONE);

        // forwarding
        bus.ex_rs1_addr = 5; bus.ex_rs2_addr = 9;
        bus.mem_valid = 1; bus.mem_wb_en = 1; bus.mem_rd_addr = 5;
        bus.wb_valid = 1; bus.wb_wb_en = 1; bus.wb_rd_addr = 5;
        #1;
        chk("fwd_mem", 32'(bus.fwd_rs1_sel), 1);
        chk("fwd_rs2_none", 32'(bus.fwd_rs2_sel), 0);
        bus.mem_is_load = 1;
        #1;
        chk("fwd_load_wb", 32'(bus.fwd_rs1_sel), 2);
        bus.mem_is_load = 0; bus.mem_rd_addr = 9;
        #1;
        chk("fwd_rs2_mem", 32'(bus.fwd_rs2_sel), 1);
        chk("fwd_rs1_wb", 32'(bus.fwd_rs1_sel), 2);
        bus.mem_wb_en = 0; bus.wb_wb_en = 0;
        #1;
        chk("fwd_no_wben", 32'(bus.fwd_rs2_sel), 0);
        bus.mem_wb_en = 1; bus.wb_wb_en = 1;
        bus.ex_rs1_addr = 0; bus.mem_rd_addr = 0; bus.wb_rd_addr = 0;
        #1;
        chk("fwd_x0", 32'(bus.fwd_rs1_sel), 0);
        idle();

        // load-use
        tick();
        set_load_use(5'd7);
        look("lu_stall", C_LU);
        tick();
        idle();
        look("lu_once", C_NONE);
        chk("lu_cnt", bus.stall_cycles, 1);
        set_load_use(5'd7);
        bus.id_rs2_used = 0;
        look("lu_unused", C_NONE);
        set_load_use(5'd0);
        look("lu_x0", C_NONE);
        idle();

        // memory wait, ack in cycle 3
        tick();
        set_mem_req();
        look("mw_c0", C_MEM);
        tick();
        look("mw_c1", C_MEM);
        tick();
        look("mw_c2", C_MEM);
        tick();
        bus.mem_ack = 1;
        look("mw_ack", C_NONE);
        tick();
        idle();
        look("mw_run", C_NONE);
        chk("mw_cnt", bus.stall_cycles, 4);

        // timeout
        tick();
        set_mem_req();
        look("to_c0", C_MEM);
        for (int i = 1; i <= 3; i++) begin
            tick();
            look($sformatf("to_w%0d", i), C_MEM);
        end
        tick();
        idle();
        look("to_fault", C_FLT);
        tick();
        look("to_run", C_NONE);
        chk("to_cnt", bus.stall_cycles, 8);

        // ack on the timeout cycle wins
        set_mem_req();
        look("toa_c0", C_MEM);
        for (int i = 1; i <= 3; i++) begin
            tick();
            look($sformatf("toa_w%0d", i), C_MEM);
        end
        tick();
        bus.mem_ack = 1;
        look("toa_ack", C_NONE);
        tick();
        idle();
        look("toa_run", C_NONE);
        chk("toa_cnt", bus.stall_cycles, 12);

        // single redirect
        set_redirect();
        look("rd_c0", C_FL);
        tick();
        idle();
        look("rd_c1", C_FIF);
        tick();
        look("rd_c2", C_FIF);
        tick();
        look("rd_c3", C_NONE);

        // second redirect reloads the drain
        set_redirect();
        look("rr_c0", C_FL);
        tick();
        look("rr_c1", C_FL);
        tick();
        idle();
        look("rr_c2", C_FIF);
        tick();
        look("rr_c3", C_FIF);
        tick();
        look("rr_c4", C_NONE);

        // redirect beats load-use
        set_load_use(5'd7);
        set_redirect();
        look("rlu_c0", C_FL);
        tick();
        idle();
        look("rlu_c1", C_FIF);
        tick();
        look("rlu_c2", C_FIF);
        tick();
        look("rlu_c3", C_NONE);

        // memory stall beats redirect
        set_redirect();
        set_mem_req();
        look("rm_c0", C_MEM);
        tick();
        look("rm_c1", C_MEM);
        tick();
        bus.mem_ack = 1;
        look("rm_ack", C_FL);
        tick();
        idle();
        look("rm_c3", C_FIF);
        tick();
        look("rm_c4", C_FIF);
        tick();
        look("rm_c5", C_NONE);

        // mem_req during REDIRECT
        set_redirect();
        look("mr_c0", C_FL);
        tick();
        idle();
        set_mem_req();
        look("mr_c1", C_MEMF);
        tick();
        bus.mem_ack = 1;
        look("mr_ack", C_FIF);
        tick();
        idle();
        look("mr_run", C_NONE);

        // reset mid-MEM_WAIT
        set_mem_req();
        look("rw_c0", C_MEM);
        tick();
        look("rw_c1", C_MEM);
        rst = 1;
        look("rw_rst", C_FL);
        tick();
        rst = 0;
        idle();
        look("rw_run", C_NONE);
        chk("rw_cnt", bus.stall_cycles, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
